// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, received word and status strobes out.
// No latency of its own; the signals are plain wires between the two ends.
// No backpressure: the line source never waits, and the strobes are fire-and-forget.
interface uart_rx_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  rx_in;
   logic [DATA_WIDTH-1:0] P_Data;
   logic                  Data_Valid;
   logic                  framing_error;
   logic                  parity_error;

   // Receiver side: consumes the line and produces the word and strobes.
   modport slave (
      input  rx_in,
      output P_Data,
      output Data_Valid,
      output framing_error,
      output parity_error
   );

   // Line driver and word consumer side.
   modport master (
      output rx_in,
      input  P_Data,
      input  Data_Valid,
      input  framing_error,
      input  parity_error
   );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: oversampled, 3-sample majority vote per bit; optional parity via UART_RX_PARITY_EN.
// Latency: strobes fire 2 + (DATA_WIDTH+1)*PRESCALE + PRESCALE/2 + 2 clks after the start edge (+PRESCALE with parity).
// No backpressure: every frame is resolved on its stop decision edge and the strobes last one cycle.
module uart_rx #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE   = 8,
   parameter int PARITY_ODD = 0
) (
   input  logic     clk,
   input  logic     RST,
   uart_rx_if.slave bus
);

   localparam int EW = $clog2(PRESCALE);
   localparam int BW = $clog2(DATA_WIDTH + 3);

   localparam logic [EW-1:0] EDGE_LAST = EW'(PRESCALE - 1);
   localparam logic [EW-1:0] SAMP0     = EW'(PRESCALE / 2 - 1);
   localparam logic [EW-1:0] SAMP1     = EW'(PRESCALE / 2);
   localparam logic [EW-1:0] SAMP2     = EW'(PRESCALE / 2 + 1);
   localparam logic [EW-1:0] DECIDE    = EW'(PRESCALE / 2 + 2);
   // bit_cnt numbers frame bits: 0 = start, 1..DATA_WIDTH = data.
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH);

   // Reject configurations the sampling window cannot handle.
   if ((PRESCALE < 6) || (PRESCALE % 2 != 0)) begin : g_bad_prescale
      $error("uart_rx: PRESCALE must be even and >= 6");
   end
   if ((DATA_WIDTH < 1) || (DATA_WIDTH > 16)) begin : g_bad_width
      $error("uart_rx: DATA_WIDTH must be 1..16");
   end
   if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity
      $error("uart_rx: PARITY_ODD must be 0 or 1");
   end

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                state_q,    state_d;
   logic [1:0]            sync_q,     sync_d;
   logic [EW-1:0]         edge_cnt_q, edge_cnt_d;
   logic [BW-1:0]         bit_cnt_q,  bit_cnt_d;
   logic [2:0]            samp_q,     samp_d;
   logic [DATA_WIDTH-1:0] shift_q,    shift_d;
   logic [DATA_WIDTH-1:0] p_data_q,   p_data_d;
   logic                  dv_q,       dv_d;
   logic                  fe_q,       fe_d;
   logic                  pe_q,       pe_d;
`ifdef UART_RX_PARITY_EN
   localparam logic ODD = PARITY_ODD[0];
   logic                  par_err_q,  par_err_d;
`endif

   logic rx_sync;
   logic bit_val;
   logic wrap;
   logic decide;
   logic frame_ok;

   assign rx_sync = sync_q[1];
   assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
   assign wrap    = (edge_cnt_q == EDGE_LAST);
   assign decide  = (edge_cnt_q == DECIDE);

   assign bus.P_Data        = p_data_q;
   assign bus.Data_Valid    = dv_q;
   assign bus.framing_error = fe_q;
   assign bus.parity_error  = pe_q;

   // Next-state, tick/bit counting, sampling, shifting and frame resolution.
   always_comb begin
      state_d    = state_q;
      sync_d     = {sync_q[0], bus.rx_in};
      edge_cnt_d = wrap ? '0 : edge_cnt_q + EW'(1);
      bit_cnt_d  = wrap ? bit_cnt_q + BW'(1) : bit_cnt_q;
      samp_d     = samp_q;
      shift_d    = shift_q;
      p_data_d   = p_data_q;
      dv_d       = 1'b0;
      fe_d       = 1'b0;
      pe_d       = 1'b0;
      frame_ok   = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_d  = par_err_q;
`endif

      // The three mid-bit samples feeding the majority vote.
      if (state_q != IDLE) begin
         if (edge_cnt_q == SAMP0) samp_d[0] = rx_sync;
         if (edge_cnt_q == SAMP1) samp_d[1] = rx_sync;
         if (edge_cnt_q == SAMP2) samp_d[2] = rx_sync;
      end

      case (state_q)
         IDLE: begin
            // The cycle that first sees the low line counts as tick 0 of the start bit.
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
            par_err_d  = 1'b0;
`endif
            if (!rx_sync) begin
               state_d    = START;
               edge_cnt_d = EW'(1);
            end
         end

         START: begin
            if (decide && bit_val) begin
               // Start bit did not hold low through mid-bit: treat as a glitch.
               state_d    = IDLE;
               edge_cnt_d = '0;
               bit_cnt_d  = '0;
            end else if (wrap) begin
               state_d = DATA;
            end
         end

         DATA: begin
            if (decide) begin
               shift_d                 = shift_q >> 1;
               shift_d[DATA_WIDTH-1]   = bit_val;
            end
            if (wrap && (bit_cnt_q == LAST_DATA)) begin
`ifdef UART_RX_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
            end
         end

`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (decide) begin
               par_err_d = (bit_val != ((^shift_q) ^ ODD));
            end
            if (wrap) begin
               state_d = STOP;
            end
         end
`endif

         STOP: begin
            // Resolve at the decision edge so a new start bit may follow at once.
            if (decide) begin
`ifdef UART_RX_PARITY_EN
               frame_ok = bit_val & ~par_err_q;
               pe_d     = par_err_q;
`else
               frame_ok = bit_val;
`endif
               fe_d       = ~bit_val;
               dv_d       = frame_ok;
               if (frame_ok) begin
                  p_data_d = shift_q;
               end
               state_d    = IDLE;
               edge_cnt_d = '0;
               bit_cnt_d  = '0;
            end
         end

         default: begin
            state_d    = IDLE;
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
         end
      endcase
   end

   // State and output registers; the synchronizer resets to the idle-high line level.
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state_q    <= IDLE;
         sync_q     <= 2'b11;
         edge_cnt_q <= '0;
         bit_cnt_q  <= '0;
         samp_q     <= 3'b111;
         shift_q    <= '0;
         p_data_q   <= '0;
         dv_q       <= 1'b0;
         fe_q       <= 1'b0;
         pe_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         edge_cnt_q <= edge_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         samp_q     <= samp_d;
         shift_q    <= shift_d;
         p_data_q   <= p_data_d;
         dv_q       <= dv_d;
         fe_q       <= fe_d;
         pe_q       <= pe_d;
`ifdef UART_RX_PARITY_EN
         par_err_q  <= par_err_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven on the serial line, expected strobes queued.
// Each strobe is checked against the queue head for kind, data and exact clk edge.
// Also checks reset values, glitch rejection, majority vote, framing and mid-frame reset.
module tb_uart_rx;
   localparam int DW = 8;
   localparam int P  = 8;
`ifdef UART_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int NBITS = 2 + DW + PB;
   localparam int LAT   = 2 + (DW + 1) * P + P / 2 + 2 + PB * P;

   localparam int K_DV   = 0;
   localparam int K_FE   = 1;
   localparam int K_PE   = 2;
   localparam int K_BOTH = 3;

   typedef struct {
      int          kind;
      logic [DW-1:0] data;
      int          cyc;
   } exp_t;

   logic clk;
   logic RST;
   int   cyc;
   int   n_tests;
   int   n_fail;
   exp_t sb[$];
   exp_t e;

   uart_rx_if #(.DATA_WIDTH(DW)) bus ();

   uart_rx #(
      .DATA_WIDTH(DW),
      .PRESCALE  (P),
      .PARITY_ODD(0)
   ) dut (
      .clk(clk),
      .RST(RST),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Drive one frame starting at a negedge; queue the strobe it should cause.
   task automatic send_frame(input logic [DW-1:0] d, input logic stop_b, input logic par_b,
                             input bit noise, input int kind, input logic [DW-1:0] exp_d);
      exp_t x;
      x.kind = kind;
      x.data = exp_d;
      x.cyc  = cyc + 1 + LAT;
      sb.push_back(x);
      for (int b = 0; b < NBITS; b++) begin
         logic v;
         if (b == 0)                         v = 1'b0;
         else if (b <= DW)                   v = d[b-1];
         else if (PB == 1 && b == DW + 1)    v = par_b;
         else                                v = stop_b;
         for (int c = 0; c < P; c++) begin
            bus.rx_in = (noise && b >= 1 && b <= DW && c == P / 2) ? ~v : v;
            @(negedge clk);
         end
      end
   endtask

   task automatic idle(input int n);
      bus.rx_in = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Every strobe must match the head of the scoreboard exactly.
   always @(negedge clk) begin
      if (RST === 1'b1 && (bus.Data_Valid !== 1'b0 || bus.framing_error !== 1'b0 ||
                           bus.parity_error !== 1'b0)) begin
         chk("strobe_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
            chk("data_valid", 32'(bus.Data_Valid), 32'(e.kind == K_DV));
            chk("framing_error", 32'(bus.framing_error), 32'(e.kind == K_FE || e.kind == K_BOTH));
            chk("parity_error", 32'(bus.parity_error), 32'(e.kind == K_PE || e.kind == K_BOTH));
            chk("p_data", 32'(bus.P_Data), 32'(e.data));
         end
      end
   end

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      cyc       = 0;
      RST       = 1'b0;
      bus.rx_in = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_p_data", 32'(bus.P_Data), 32'h0);
      chk("reset_dv", 32'(bus.Data_Valid), 32'h0);
      chk("reset_fe", 32'(bus.framing_error), 32'h0);
      chk("reset_pe", 32'(bus.parity_error), 32'h0);
      RST = 1'b1;
      idle(5);

      // Plain frame.
      send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0, K_DV, 8'hA5);
      idle(2 * P);

      // Back-to-back frames, next start right after the stop bit.
      send_frame(8'h3C, 1'b1, ^8'h3C, 1'b0, K_DV, 8'h3C);
      send_frame(8'hFF, 1'b1, ^8'hFF, 1'b0, K_DV, 8'hFF);
      idle(2 * P);

      // Short low glitch must be rejected, then a normal frame.
      bus.rx_in = 1'b0;
      repeat (3) @(negedge clk);
      idle(3 * P);
      send_frame(8'h55, 1'b1, ^8'h55, 1'b0, K_DV, 8'h55);
      idle(2 * P);

      // Stop bit low: framing error, previous word held.
      send_frame(8'h81, 1'b0, ^8'h81, 1'b0, K_FE, 8'h55);
      idle(3 * P);

      // One corrupted mid-bit sample per data bit.
      send_frame(8'h0F, 1'b1, ^8'h0F, 1'b1, K_DV, 8'h0F);
      idle(2 * P);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1, 1'b0, K_DV, 8'h07);
      idle(2 * P);
      send_frame(8'h07, 1'b1, 1'b0, 1'b0, K_PE, 8'h07);
      idle(2 * P);
      send_frame(8'h07, 1'b0, 1'b0, 1'b0, K_BOTH, 8'h07);
      idle(3 * P);
`endif

      // Reset partway through a frame: no strobe, word cleared.
      bus.rx_in = 1'b0;
      repeat (3 * P) @(negedge clk);
      RST       = 1'b0;
      bus.rx_in = 1'b1;
      repeat (2) @(negedge clk);
      chk("midrst_p_data", 32'(bus.P_Data), 32'h0);
      chk("midrst_dv", 32'(bus.Data_Valid), 32'h0);
      chk("midrst_fe", 32'(bus.framing_error), 32'h0);
      chk("midrst_pe", 32'(bus.parity_error), 32'h0);
      RST = 1'b1;
      idle(5);
      send_frame(8'hC3, 1'b1, ^8'hC3, 1'b0, K_DV, 8'hC3);

      // Let outstanding strobes arrive, bounded.
      for (int i = 0; i < 4 * LAT; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      idle(2 * P);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
